// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the TLP transceiver: action words exchanged with tlp_send,
// TLP fmt/type codes and a packed 3DW header view for field extraction.
package tlp_xcvr_pkg;

    typedef logic [15:0] BusID;
    typedef logic [7:0]  Tag;
    typedef logic [31:0] Data;

    localparam int CHAN_W = 4;
    typedef logic [CHAN_W-1:0] Channel;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_READ  = 2'd1,
        ACT_WRITE = 2'd2
    } ActType;

    typedef struct packed {
        BusID reqID;
        Tag   tag;
    } RegRead;

    typedef struct packed {
        Data data;
    } RegWrite;

    typedef struct packed {
        ActType  typ;
        Channel  chan;
        RegRead  rd;
        RegWrite wr;
    } Action;

    // fmt/type byte (DW0[31:24]) of the TLPs this block understands
    localparam logic [7:0] MRD32 = 8'h00;
    localparam logic [7:0] MWR32 = 8'h40;
    localparam logic [7:0] CPLD  = 8'h4A;

    // DW0 sits in the low bits, DW2 in the high bits, matching beat order.
    // DW1/DW2 fields are named by request layout; completions reuse them:
    // DW1 tagSts[7:5] = completion status, DW2 addr[15:8] = completion tag,
    // DW2 addr[6:0] = lower address.
    typedef struct packed {
        logic [31:0] addr;
        BusID        id;
        logic [7:0]  tagSts;
        logic [7:0]  be;
        logic [7:0]  fmtType;
        logic [13:0] rsvd;
        logic [9:0]  len;
    } TlpHdr3;

    function automatic Action mkRead(BusID id, Tag t, Channel c);
        Action a;
        a          = '0;
        a.typ      = ACT_READ;
        a.chan     = c;
        a.rd.reqID = id;
        a.rd.tag   = t;
        return a;
    endfunction

    function automatic Action mkWrite(Channel c, Data d);
        Action a;
        a         = '0;
        a.typ     = ACT_WRITE;
        a.chan    = c;
        a.wr.data = d;
        return a;
    endfunction

    function automatic logic [15:0] satInc16(logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tlp_hdr_decode.sv
// Combinational classification of a 3DW TLP header into register read,
// register write, accepted DMA completion or drop.
module tlp_hdr_decode
    import tlp_xcvr_pkg::*;
#(
    parameter logic [7:0] DMA_TAG = 8'h0C
) (
    input  TlpHdr3     hdr_i,
    output logic       isRegRd_o,
    output logic       isRegWr_o,
    output logic       wrInline_o,
    output logic       isDmaCmp_o,
    output logic       drop_o,
    output logic [3:0] cmpQwLeft_o
);

    logic       lenOne;
    logic       cmpLenOk;
    logic [4:0] qwCnt;
    logic       unusedBits;

    // Classify the header; a completion payload must be whole QWs, at most 16
    always_comb begin
        lenOne      = (hdr_i.len == 10'd1);
        cmpLenOk    = (hdr_i.len != 10'd0) && !hdr_i.len[0] && (hdr_i.len <= 10'd32);
        qwCnt       = hdr_i.len[5:1];
        isRegRd_o   = (hdr_i.fmtType == MRD32) && lenOne;
        isRegWr_o   = (hdr_i.fmtType == MWR32) && lenOne;
        wrInline_o  = hdr_i.addr[2];
        isDmaCmp_o  = (hdr_i.fmtType == CPLD)
                      && (hdr_i.addr[15:8] == DMA_TAG)
                      && (hdr_i.tagSts[7:5] == 3'd0)
                      && !hdr_i.addr[2]
                      && cmpLenOk;
        drop_o      = !(isRegRd_o || isRegWr_o || isDmaCmp_o);
        cmpQwLeft_o = 4'(qwCnt - 5'd1);
    end

    assign unusedBits = ^{hdr_i.rsvd, hdr_i.be, hdr_i.id, hdr_i.tagSts[4:0],
                          hdr_i.addr[31:16], hdr_i.addr[7:3], hdr_i.addr[1:0]};

endmodule

// File: rtl/tlp_recv.sv
// PCIe RX TLP parser: turns 1-DW register MWr/MRd into action words and
// streams DMA-read completion payload to the CPU->FPGA pipe; drops the rest.
module tlp_recv
    import tlp_xcvr_pkg::*;
#(
    parameter logic [7:0] DMA_TAG  = 8'h0C,
    parameter int         CHAN_LSB = 2
) (
    input  logic        pcieClk_in,
    input  logic        pcieRstN_in,
    input  logic [63:0] rxData_in,
    input  logic        rxValid_in,
    output logic        rxReady_out,
    input  logic        rxSOP_in,
    input  logic        rxEOP_in,
    output Action       actData_out,
    output logic        actValid_out,
    input  logic        actReady_in,
    output logic [63:0] c2fData_out,
    output logic        c2fValid_out,
    input  logic        c2fReady_in,
    output logic [15:0] dropCount_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_WR_DATA,
        S_CMP_DATA,
        S_DISCARD
    } state_t;

    state_t      state_q;
    logic [7:0]  fmtType_q;
    logic [9:0]  len_q;
    BusID        reqId_q;
    logic [7:0]  tagSts_q;
    Channel      chan_q;
    logic [3:0]  qwLeft_q;
    Action       act_q;
    logic        actValid_q;
    logic [15:0] dropCnt_q;
    logic [15:0] dropCnt_d;

    logic        acc;
    logic        dropEv;
    TlpHdr3      hdr;
    Channel      rxChan;
    logic        decRd, decWr, decInline, decCmp, decDrop;
    logic [3:0]  decQwLeft;

    assign acc       = rxValid_in && rxReady_out;
    assign rxChan    = rxData_in[CHAN_LSB +: CHAN_W];
    assign dropCnt_d = satInc16(dropCnt_q);

    assign actData_out   = act_q;
    assign actValid_out  = actValid_q;
    assign dropCount_out = dropCnt_q;
    assign c2fData_out   = rxData_in;
    // A SOP beat during payload starts a new TLP and is never payload itself
    assign c2fValid_out  = (state_q == S_CMP_DATA) && rxValid_in && !rxSOP_in;

    // Header view: DW0/DW1 from the captured SOP beat, DW2 from the current beat
    always_comb begin
        hdr         = '0;
        hdr.addr    = rxData_in[31:0];
        hdr.id      = reqId_q;
        hdr.tagSts  = tagSts_q;
        hdr.fmtType = fmtType_q;
        hdr.len     = len_q;
    end

    tlp_hdr_decode #(
        .DMA_TAG(DMA_TAG)
    ) u_dec (
        .hdr_i       (hdr),
        .isRegRd_o   (decRd),
        .isRegWr_o   (decWr),
        .wrInline_o  (decInline),
        .isDmaCmp_o  (decCmp),
        .drop_o      (decDrop),
        .cmpQwLeft_o (decQwLeft)
    );

    // RX backpressure: register beats wait for the pending action, payload follows c2f
    always_comb begin
        rxReady_out = !actValid_q;
        case (state_q)
            S_CMP_DATA: rxReady_out = c2fReady_in;
            S_DISCARD:  rxReady_out = 1'b1;
            default:    rxReady_out = !actValid_q;
        endcase
    end

    // Drop events: undecodable header, truncation by a new SOP, or short completion
    always_comb begin
        dropEv = 1'b0;
        if (acc) begin
            case (state_q)
                S_HDR1:     dropEv = rxSOP_in || decDrop;
                S_WR_DATA:  dropEv = rxSOP_in;
                S_CMP_DATA: dropEv = rxSOP_in || (rxEOP_in && (qwLeft_q != 4'd0));
                default:    dropEv = 1'b0;
            endcase
        end
    end

    // Parser FSM with registered action output and saturating drop counter
    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) begin
            state_q    <= S_IDLE;
            fmtType_q  <= '0;
            len_q      <= '0;
            reqId_q    <= '0;
            tagSts_q   <= '0;
            chan_q     <= '0;
            qwLeft_q   <= '0;
            act_q      <= '0;
            actValid_q <= 1'b0;
            dropCnt_q  <= '0;
        end else begin
            if (actValid_q && actReady_in) begin
                actValid_q <= 1'b0;
            end
            if (dropEv) begin
                dropCnt_q <= dropCnt_d;
            end
            if (acc) begin
                if (rxSOP_in && (state_q != S_DISCARD)) begin
                    fmtType_q <= rxData_in[31:24];
                    len_q     <= rxData_in[9:0];
                    reqId_q   <= rxData_in[63:48];
                    tagSts_q  <= rxData_in[47:40];
                    state_q   <= S_HDR1;
                end else begin
                    case (state_q)
                        S_HDR1: begin
                            chan_q <= rxChan;
                            if (decRd) begin
                                act_q      <= mkRead(reqId_q, tagSts_q, rxChan);
                                actValid_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end else if (decWr && decInline) begin
                                act_q      <= mkWrite(rxChan, rxData_in[63:32]);
                                actValid_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end else if (decWr) begin
                                state_q <= S_WR_DATA;
                            end else if (decCmp) begin
                                qwLeft_q <= decQwLeft;
                                state_q  <= S_CMP_DATA;
                            end else begin
                                state_q <= rxEOP_in ? S_IDLE : S_DISCARD;
                            end
                        end
                        S_WR_DATA: begin
                            act_q      <= mkWrite(chan_q, rxData_in[31:0]);
                            actValid_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end
                        S_CMP_DATA: begin
                            if ((qwLeft_q == 4'd0) || rxEOP_in) begin
                                state_q <= S_IDLE;
                            end else begin
                                qwLeft_q <= qwLeft_q - 4'd1;
                            end
                        end
                        S_DISCARD: begin
                            if (rxEOP_in) begin
                                state_q <= S_IDLE;
                            end
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tlp_recv.sv
// Directed bench for tlp_recv: register writes/reads, action backpressure,
// DMA completion streaming, drops and reset in the middle of a completion.
module tb_tlp_recv;
    import tlp_xcvr_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] rxData = '0;
    logic        rxValid = 1'b0;
    logic        rxSOP = 1'b0;
    logic        rxEOP = 1'b0;
    logic        actReady = 1'b1;
    logic        c2fReady = 1'b1;
    logic        rxReady;
    Action       actData;
    logic        actValid;
    logic [63:0] c2fData;
    logic        c2fValid;
    logic [15:0] dropCount;

    int          checks = 0;
    int          errors = 0;
    int          actCnt = 0;
    logic [63:0] c2fQ[$];
    logic        tog = 1'b0;

    always #4 clk = ~clk;

    tlp_recv #(
        .DMA_TAG (8'h0C),
        .CHAN_LSB(2)
    ) dut (
        .pcieClk_in   (clk),
        .pcieRstN_in  (rstn),
        .rxData_in    (rxData),
        .rxValid_in   (rxValid),
        .rxReady_out  (rxReady),
        .rxSOP_in     (rxSOP),
        .rxEOP_in     (rxEOP),
        .actData_out  (actData),
        .actValid_out (actValid),
        .actReady_in  (actReady),
        .c2fData_out  (c2fData),
        .c2fValid_out (c2fValid),
        .c2fReady_in  (c2fReady),
        .dropCount_out(dropCount)
    );

    // Record every handshake on the action and c2f outputs
    always @(negedge clk) begin
        if (actValid && actReady) actCnt <= actCnt + 1;
        if (c2fValid && c2fReady) c2fQ.push_back(c2fData);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic s, input logic e);
        logic ok;
        ok      = 1'b0;
        rxData  = d;
        rxSOP   = s;
        rxEOP   = e;
        rxValid = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            ok = rxReady;
            @(posedge clk);
            #1;
            if (tog) c2fReady = ~c2fReady;
        end
        if (!ok) chk("send_ready", {63'b0, ok}, 64'd1);
    endtask

    task automatic idle();
        rxValid = 1'b0;
        rxSOP   = 1'b0;
        rxEOP   = 1'b0;
    endtask

    function automatic logic [63:0] pay(input int i);
        return {32'hC0DE0000 + 32'(i), 32'(i)};
    endfunction

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_actValid", {63'b0, actValid}, 64'd0);
        chk("rst_actData", 64'(actData), 64'd0);
        chk("rst_drop", 64'(dropCount), 64'd0);
        chk("rst_c2fValid", {63'b0, c2fValid}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_rxReady", {63'b0, rxReady}, 64'd1);

        // MWr32 addr 0x14, data inline in the header beat
        send({32'h0100000F, 32'h40000001}, 1'b1, 1'b0);
        send({32'h12345678, 32'h00000014}, 1'b0, 1'b1);
        idle();
        chk("w1_valid", {63'b0, actValid}, 64'd1);
        chk("w1_typ", 64'(actData.typ), 64'(ACT_WRITE));
        chk("w1_chan", 64'(actData.chan), 64'd5);
        chk("w1_data", 64'(actData.wr.data), 64'h12345678);
        @(posedge clk);
        #1;
        chk("w1_cleared", {63'b0, actValid}, 64'd0);
        chk("w1_cnt", 64'(actCnt), 64'd1);

        // MWr32 addr 0x10, data in the following beat, action held by actReady=0
        actReady = 1'b0;
        send({32'h0100000F, 32'h40000001}, 1'b1, 1'b0);
        send({32'hDEADBEEF, 32'h00000010}, 1'b0, 1'b0);
        send({32'h00000000, 32'hCAFEF00D}, 1'b0, 1'b1);
        chk("w2_valid", {63'b0, actValid}, 64'd1);
        chk("w2_typ", 64'(actData.typ), 64'(ACT_WRITE));
        chk("w2_chan", 64'(actData.chan), 64'd4);
        chk("w2_data", 64'(actData.wr.data), 64'hCAFEF00D);
        rxData  = {32'h0100070F, 32'h00000001};
        rxSOP   = 1'b1;
        rxEOP   = 1'b0;
        rxValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("w2_hold_rxReady", {63'b0, rxReady}, 64'd0);
            chk("w2_hold_valid", {63'b0, actValid}, 64'd1);
            chk("w2_hold_data", 64'(actData), 64'(mkWrite(4'd4, 32'hCAFEF00D)));
        end
        @(posedge clk);
        #1;
        actReady = 1'b1;

        // MRd32 reqID 0x0100 tag 0x07 addr 0x08 (header beat already presented)
        send({32'h0100070F, 32'h00000001}, 1'b1, 1'b0);
        chk("w2_cnt", 64'(actCnt), 64'd2);
        send({32'h00000000, 32'h00000008}, 1'b0, 1'b1);
        idle();
        chk("r1_valid", {63'b0, actValid}, 64'd1);
        chk("r1_typ", 64'(actData.typ), 64'(ACT_READ));
        chk("r1_reqID", 64'(actData.rd.reqID), 64'h0100);
        chk("r1_tag", 64'(actData.rd.tag), 64'h07);
        chk("r1_chan", 64'(actData.chan), 64'd2);
        @(posedge clk);
        #1;
        chk("r1_cnt", 64'(actCnt), 64'd3);

        // CplD tag 0x0C, length 32: 16 QWs with c2fReady toggling
        send({32'h00000080, 32'h4A000020}, 1'b1, 1'b0);
        send({32'h00000000, 32'h00000C00}, 1'b0, 1'b0);
        c2fReady = 1'b1;
        tog      = 1'b1;
        for (int i = 0; i < 16; i++) send(pay(i), 1'b0, (i == 15));
        tog      = 1'b0;
        c2fReady = 1'b1;
        idle();
        @(posedge clk);
        #1;
        chk("cmp_count", 64'(c2fQ.size()), 64'd16);
        for (int i = 0; i < 16 && i < c2fQ.size(); i++) chk("cmp_qw", c2fQ[i], pay(i));
        chk("cmp_drop", 64'(dropCount), 64'd0);
        chk("cmp_act", 64'(actCnt), 64'd3);

        // CplD with foreign tag, then MWr32 length 2: both dropped
        send({32'h00000008, 32'h4A000002}, 1'b1, 1'b0);
        send({32'hAAAA5555, 32'h00000500}, 1'b0, 1'b0);
        send(64'h1, 1'b0, 1'b1);
        send({32'h0100000F, 32'h40000002}, 1'b1, 1'b0);
        send({32'h00000000, 32'h00000010}, 1'b0, 1'b0);
        send({32'h00000011, 32'h00000022}, 1'b0, 1'b1);
        idle();
        @(posedge clk);
        #1;
        chk("drop_count", 64'(dropCount), 64'd2);
        chk("drop_act", 64'(actCnt), 64'd3);
        chk("drop_valid", {63'b0, actValid}, 64'd0);
        chk("drop_c2f", 64'(c2fQ.size()), 64'd16);

        // reset on payload beat 8 of a DMA completion
        send({32'h00000080, 32'h4A000020}, 1'b1, 1'b0);
        send({32'h00000000, 32'h00000C00}, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send(pay(i), 1'b0, 1'b0);
        rxData  = pay(8);
        rxSOP   = 1'b0;
        rxEOP   = 1'b0;
        rxValid = 1'b1;
        rstn    = 1'b0;
        #1;
        chk("mid_rst_c2fValid", {63'b0, c2fValid}, 64'd0);
        chk("mid_rst_rxReady", {63'b0, rxReady}, 64'd1);
        chk("mid_rst_drop", 64'(dropCount), 64'd0);
        chk("mid_rst_actData", 64'(actData), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 8; i < 16; i++) send(pay(i), 1'b0, (i == 15));
        idle();
        @(posedge clk);
        #1;
        chk("post_rst_c2f", 64'(c2fQ.size()), 64'd24);
        chk("post_rst_drop", 64'(dropCount), 64'd0);
        chk("post_rst_act", 64'(actCnt), 64'd3);

        // MRd32 after reset: reqID 0x0200 tag 0x33 addr 0x3C
        send({32'h0200330F, 32'h00000001}, 1'b1, 1'b0);
        send({32'h00000000, 32'h0000003C}, 1'b0, 1'b1);
        idle();
        chk("r2_valid", {63'b0, actValid}, 64'd1);
        chk("r2_typ", 64'(actData.typ), 64'(ACT_READ));
        chk("r2_reqID", 64'(actData.rd.reqID), 64'h0200);
        chk("r2_tag", 64'(actData.rd.tag), 64'h33);
        chk("r2_chan", 64'(actData.chan), 64'd15);
        @(posedge clk);
        #1;
        chk("r2_cnt", 64'(actCnt), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
